// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: sequential instruction front end.
// Issues req/ack fetches to instruction memory, buffers {pc, instr} in a
// DEPTH-entry queue, presents the head to decode over valid/ready and
// handles redirects by flushing the queue and discarding a stale in-flight fetch.
// Optional build macro: IFU_BYPASS_EN (an acked word bypasses the empty queue
// straight to the outputs in the same cycle).
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | no request outstanding (queue full, or waiting to start)
// S_WAIT    | request at fetch_pc outstanding, waiting for imem_ack_i
// S_DISCARD | stale request held until acked, its data dropped
module instr_fetch_unit #(
    parameter int              ADDR_WIDTH  = 32,
    parameter int              INSTR_WIDTH = 32,
    parameter int              DEPTH       = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    output logic                   imem_req_o,
    output logic [ADDR_WIDTH-1:0]  imem_addr_o,
    input  logic                   imem_ack_i,
    input  logic [INSTR_WIDTH-1:0] imem_data_i,
    input  logic                   redirect_i,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [INSTR_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0]  pc_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DISCARD} state_t;

    state_t                 state, state_nxt;
    logic [ADDR_WIDTH-1:0]  fetch_pc;
    logic [ADDR_WIDTH-1:0]  stale_addr;
    logic [CW-1:0]          count, cnt_after, cnt_popped;
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic [INSTR_WIDTH-1:0] instr_q [DEPTH];
    logic [ADDR_WIDTH-1:0]  pc_q    [DEPTH];
    logic                   q_valid, pop, push, ack_wait, byp;
    logic [ADDR_WIDTH-1:0]  redir_pc;
    logic                   unused_redir_bits;

    assign unused_redir_bits = ^redirect_pc_i[1:0];
    assign redir_pc  = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
    assign q_valid   = (count != '0);
    assign ack_wait  = (state == S_WAIT) && imem_ack_i && !redirect_i;

`ifdef IFU_BYPASS_EN
    assign byp = !q_valid && ack_wait;
`else
    assign byp = 1'b0;
`endif

    // Queue pop/push qualification and resulting occupancy.
    always_comb begin
        pop        = q_valid && ready_i;
        push       = ack_wait && !(byp && ready_i);
        cnt_popped = count - CW'(pop);
        cnt_after  = cnt_popped + CW'(push);
    end

    // Decode-side outputs, forced to zero when nothing is valid.
    always_comb begin
        valid_o = q_valid || byp;
        instr_o = '0;
        pc_o    = '0;
        if (q_valid) begin
            instr_o = instr_q[rd_ptr];
            pc_o    = pc_q[rd_ptr];
        end else if (byp) begin
            instr_o = imem_data_i;
            pc_o    = fetch_pc;
        end
    end

    // Memory request outputs follow the state directly.
    always_comb begin
        imem_req_o  = (state != S_IDLE);
        imem_addr_o = '0;
        if (state == S_WAIT)
            imem_addr_o = fetch_pc;
        else if (state == S_DISCARD)
            imem_addr_o = stale_addr;
    end

    // Next-state logic; a redirect overrides the normal flow.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (redirect_i || (cnt_popped < FULL))
                    state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (redirect_i)
                    state_nxt = imem_ack_i ? S_WAIT : S_DISCARD;
                else if (imem_ack_i)
                    state_nxt = (cnt_after < FULL) ? S_WAIT : S_IDLE;
            end
            S_DISCARD: begin
                if (imem_ack_i)
                    state_nxt = S_WAIT;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State, fetch address, stale address and queue bookkeeping.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= S_IDLE;
            fetch_pc   <= RESET_PC;
            stale_addr <= '0;
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            state <= state_nxt;
            if (redirect_i) begin
                fetch_pc <= redir_pc;
                count    <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                if (state == S_WAIT && !imem_ack_i)
                    stale_addr <= fetch_pc;
            end else begin
                if (ack_wait)
                    fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
                if (push)
                    wr_ptr <= wr_ptr + PW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
                count <= cnt_after;
            end
        end
    end

    // Queue storage; written only on a qualified push.
    always_ff @(posedge clk_i) begin
        if (push) begin
            instr_q[wr_ptr] <= imem_data_i;
            pc_q[wr_ptr]    <= fetch_pc;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit (default build, DEPTH=4, RESET_PC=0x100).
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req, ack, redir, valid, ready;
    logic [31:0] addr, data, rpc, instr, pc;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .ADDR_WIDTH(32), .INSTR_WIDTH(32), .DEPTH(4), .RESET_PC(32'h100)
    ) dut (
        .clk_i(clk), .rst_i(rst_n),
        .imem_req_o(req), .imem_addr_o(addr),
        .imem_ack_i(ack), .imem_data_i(data),
        .redirect_i(redir), .redirect_pc_i(rpc),
        .valid_o(valid), .ready_i(ready),
        .instr_o(instr), .pc_o(pc)
    );

    // Memory contents: a fixed pattern of the address.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ack = 0; redir = 0; rpc = '0; data = '0;
        cyc(); cyc();
        chk("rst_req", {31'd0, req}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_addr", addr, 32'd0);
        chk("rst_pc", pc, 32'd0);
        rst_n = 1'b1;
        cyc();
        chk("first_req", {31'd0, req}, 32'd1);
        chk("first_addr", addr, 32'h100);
    endtask

    int n_acks;

    initial begin
        ready = 1'b1;
        // Sequential fetch, same-cycle ack, ready high.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            ack = 1; data = mem(addr);
            cyc();
            chk("seq_valid", {31'd0, valid}, 32'd1);
            chk("seq_pc", pc, 32'h100 + 32'(4 * k));
            chk("seq_instr", instr, mem(32'h100 + 32'(4 * k)));
            chk("seq_addr", addr, 32'h104 + 32'(4 * k));
        end

        // Fill with ready low: exactly four acks, then request drops.
        ready = 1'b0;
        do_reset();
        n_acks = 0;
        for (int k = 0; k < 8; k++) begin
            ack = req; data = mem(addr);
            if (req) n_acks++;
            cyc();
        end
        chk("fill_acks", 32'(n_acks), 32'd4);
        chk("fill_req", {31'd0, req}, 32'd0);
        chk("fill_head", pc, 32'h100);
        ack = 0; ready = 1'b1;
        cyc();
        chk("drain_req", {31'd0, req}, 32'd1);
        chk("drain_addr", addr, 32'h110);
        chk("drain_pc1", pc, 32'h104);
        cyc();
        chk("drain_pc2", pc, 32'h108);
        cyc();
        chk("drain_pc3", pc, 32'h10C);
        chk("drain_instr3", instr, mem(32'h10C));
        cyc();
        chk("drain_empty", {31'd0, valid}, 32'd0);

        // Slow memory, redirect while waiting -> stale fetch discarded.
        do_reset();
        ack = 0;
        cyc(); cyc();
        chk("slow_addr_hold", addr, 32'h100);
        redir = 1; rpc = 32'h2003;
        cyc();
        redir = 0;
        chk("disc_addr", addr, 32'h100);
        chk("disc_req", {31'd0, req}, 32'd1);
        chk("disc_valid", {31'd0, valid}, 32'd0);
        ack = 1; data = 32'hBAD0_BAD0;
        cyc();
        chk("disc_valid2", {31'd0, valid}, 32'd0);
        chk("redir_addr", addr, 32'h2000);
        data = mem(addr);
        cyc();
        chk("redir_pc", pc, 32'h2000);
        chk("redir_instr", instr, mem(32'h2000));

        // Redirect with same-cycle ack and downstream transfer.
        chk("pre_valid", {31'd0, valid}, 32'd1);
        ack = 1; data = mem(addr); redir = 1; rpc = 32'h3000;
        cyc();
        redir = 0; ack = 0;
        chk("rdack_valid", {31'd0, valid}, 32'd0);
        chk("rdack_req", {31'd0, req}, 32'd1);
        chk("rdack_addr", addr, 32'h3000);

        // Address wrap past the top of the space.
        ack = 1; data = mem(addr); redir = 1; rpc = 32'hFFFF_FFFE;
        cyc();
        redir = 0;
        chk("wrap_addr0", addr, 32'hFFFF_FFFC);
        data = mem(addr);
        cyc();
        chk("wrap_addr1", addr, 32'h0000_0000);
        chk("wrap_pc", pc, 32'hFFFF_FFFC);

        // Asynchronous reset mid-WAIT.
        ack = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_req", {31'd0, req}, 32'd0);
        chk("async_valid", {31'd0, valid}, 32'd0);
        chk("async_instr", instr, 32'd0);
        chk("async_pc", pc, 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("restart_addr", addr, 32'h100);
        chk("restart_req", {31'd0, req}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
